// File: rtl/game_ctrl.sv
// game_ctrl: frame-rate FlappyBird engine producing game state, bird, tubes and score.
module game_ctrl #(
  parameter int V_ACTIVE     = 480,
  parameter int BIRD_LOC_X   = 128,
  parameter int BIRD_SIZE    = 32,
  parameter int BIRD_Y0      = 224,
  parameter int TUBE_GAP     = 80,
  parameter int TUBE_WIDTH   = 56,
  parameter int TUBE_SPACING = 160,
  parameter int TUBE_X0      = 700,
  parameter int TUBE_H0      = 160,
  parameter int TUBE_SPEED   = 2,
  parameter int GRAVITY      = 1,
  parameter int FLAP_VEL     = 8,
  parameter int VEL_MAX      = 10,
  parameter int BORDER       = 5,
  parameter int OVER_HOLD    = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs_in,
  input  logic        key_flap,
  output logic [1:0]  state,
  output logic [11:0] bird_loc_y,
  output logic [11:0] tube0_x,
  output logic [11:0] tube1_x,
  output logic [11:0] tube2_x,
  output logic [11:0] tube3_x,
  output logic [11:0] tube4_x,
  output logic [11:0] tube0_h,
  output logic [11:0] tube1_h,
  output logic [11:0] tube2_h,
  output logic [11:0] tube3_h,
  output logic [11:0] tube4_h,
  output logic [7:0]  score
);
  typedef enum logic [1:0] {S_START = 2'd0, S_END = 2'd1, S_PLAY = 2'd2} state_t;
  localparam logic [11:0] Y_FLOOR = 12'(V_ACTIVE - BORDER - BIRD_SIZE);
  localparam logic [11:0] X_LO    = 12'(BIRD_LOC_X);
  localparam logic [11:0] X_HI    = 12'(BIRD_LOC_X + BIRD_SIZE + TUBE_WIDTH);
  localparam logic [11:0] X_PASS  = 12'(BIRD_LOC_X + TUBE_SPEED);
  localparam logic [11:0] GAP_LO  = 12'(TUBE_GAP - BIRD_SIZE);
  localparam logic [11:0] SPD     = 12'(TUBE_SPEED);
  localparam logic [11:0] WRAP    = 12'(5 * TUBE_SPACING - TUBE_SPEED);
  localparam logic [11:0] H_MIN   = 12'd64;
  localparam logic [11:0] Y_TOP   = 12'(BORDER);
  localparam logic [11:0] Y_INIT  = 12'(BIRD_Y0);
  localparam logic [11:0] H_INIT  = 12'(TUBE_H0);
  localparam logic signed [7:0] V_FLAP = 8'(-FLAP_VEL);
  localparam logic signed [7:0] V_MAX  = 8'(VEL_MAX);
  localparam logic signed [7:0] V_G    = 8'(GRAVITY);
  localparam logic signed [7:0] V_SAT  = 8'(VEL_MAX - GRAVITY);
  localparam logic signed [12:0] NY_MIN = 13'(BORDER);
  localparam logic [7:0] HOLD = 8'(OVER_HOLD);
  state_t st;
  logic vs_d, key_d, armed, flap_pend, tick, flap, hit, pass;
  logic [15:0] lfsr;
  logic signed [7:0] vel, vel_nx;
  logic signed [12:0] ny;
  logic [11:0] y;
  logic [11:0] tx [5];
  logic [11:0] th [5];
  logic [7:0] hold, sc;
  // armed blocks a spurious tick when vs_in is already high as reset releases
  assign tick = vs_in & ~vs_d & armed;
  assign flap = flap_pend | (key_flap & ~key_d);
  assign ny = $signed({1'b0, y}) + $signed({{5{vel[7]}}, vel});
  assign vel_nx = flap ? V_FLAP : (vel >= V_SAT) ? V_MAX : vel + V_G;
  assign state = st;
  assign bird_loc_y = y;
  assign score = sc;
  assign tube0_x = tx[0];
  assign tube1_x = tx[1];
  assign tube2_x = tx[2];
  assign tube3_x = tx[3];
  assign tube4_x = tx[4];
  assign tube0_h = th[0];
  assign tube1_h = th[1];
  assign tube2_h = th[2];
  assign tube3_h = th[3];
  assign tube4_h = th[4];
  always_comb begin
    hit = y > Y_FLOOR;
    pass = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hit = hit | (tx[i] > X_LO && tx[i] < X_HI && (y < th[i] || y > th[i] + GAP_LO));
      pass = pass | (tx[i] > X_LO && tx[i] <= X_PASS);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= S_START;
      vs_d <= 1'b0;
      key_d <= 1'b0;
      armed <= 1'b0;
      flap_pend <= 1'b0;
      lfsr <= 16'hACE1;
      vel <= 8'sd0;
      y <= Y_INIT;
      hold <= 8'd0;
      sc <= 8'd0;
      for (int i = 0; i < 5; i++) begin
        tx[i] <= 12'(TUBE_X0 + i * TUBE_SPACING);
        th[i] <= H_INIT;
      end
    end else begin
      vs_d <= vs_in;
      key_d <= key_flap;
      armed <= armed | ~vs_in;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      flap_pend <= ~tick & flap;
      if (tick) begin
        case (st)
          S_START: if (flap) st <= S_PLAY;
          S_PLAY: begin
            if (hit) st <= S_END;
            else begin
              y <= (ny < NY_MIN) ? Y_TOP : ny[11:0];
              vel <= (ny < NY_MIN) ? 8'sd0 : vel_nx;
              sc <= (pass && sc != 8'hFF) ? sc + 8'd1 : sc;
              for (int i = 0; i < 5; i++) begin
                tx[i] <= (tx[i] <= SPD) ? tx[i] + WRAP : tx[i] - SPD;
                if (tx[i] <= SPD) th[i] <= H_MIN + {4'd0, lfsr[7:0]};
              end
            end
          end
          S_END: begin
            if (flap && hold == HOLD) begin
              st <= S_START;
              vel <= 8'sd0;
              y <= Y_INIT;
              hold <= 8'd0;
              sc <= 8'd0;
              for (int i = 0; i < 5; i++) begin
                tx[i] <= 12'(TUBE_X0 + i * TUBE_SPACING);
                th[i] <= H_INIT;
              end
            end else hold <= (hold == HOLD) ? hold : hold + 8'd1;
          end
          default: st <= S_START;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: randomized frames against a rule-level game model, checked via a scoreboard queue.
module tb_game_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, vs_in = 1'b0, key_flap = 1'b0;
  logic [1:0] state;
  logic [11:0] bird_loc_y, tube0_x, tube1_x, tube2_x, tube3_x, tube4_x;
  logic [11:0] tube0_h, tube1_h, tube2_h, tube3_h, tube4_h;
  logic [7:0] score;
  game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .key_flap(key_flap), .state(state),
    .bird_loc_y(bird_loc_y), .tube0_x(tube0_x), .tube1_x(tube1_x), .tube2_x(tube2_x),
    .tube3_x(tube3_x), .tube4_x(tube4_x), .tube0_h(tube0_h), .tube1_h(tube1_h),
    .tube2_h(tube2_h), .tube3_h(tube3_h), .tube4_h(tube4_h), .score(score)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [31:0] due;
    logic [1:0] st;
    logic [11:0] y;
    logic [7:0] sc;
    logic [4:0][11:0] tx;
    logic [4:0][11:0] th;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  int m_st, m_y, m_vel, m_sc, m_hold, m_lfsr;
  int m_tx[5], m_th[5];
  logic [11:0] d_tx[5], d_th[5];
  assign d_tx = '{tube0_x, tube1_x, tube2_x, tube3_x, tube4_x};
  assign d_th = '{tube0_h, tube1_h, tube2_h, tube3_h, tube4_h};
  always @(posedge clk) cyc <= cyc + 1;
  // free-running x^16+x^14+x^13+x^11+1 sequence, seeded at reset
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= 'hACE1;
    else m_lfsr <= ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 'hFFFF;
  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endfunction
  function automatic void reset_model();
    m_st = 0; m_y = 224; m_vel = 0; m_sc = 0; m_hold = 0;
    for (int i = 0; i < 5; i++) begin
      m_tx[i] = 700 + 160 * i;
      m_th[i] = 160;
    end
  endfunction
  function automatic void push();
    exp_t e;
    e.due = 32'(cyc + 1);
    e.st = 2'(m_st);
    e.y = 12'(m_y);
    e.sc = 8'(m_sc);
    for (int i = 0; i < 5; i++) begin
      e.tx[i] = 12'(m_tx[i]);
      e.th[i] = 12'(m_th[i]);
    end
    q.push_back(e);
  endfunction
  function automatic void model_tick(bit flap);
    int ny;
    bit col, pass;
    if (m_st == 0) begin
      if (flap) m_st = 2;
    end else if (m_st == 2) begin
      col = (m_y + 32 > 475);
      for (int i = 0; i < 5; i++)
        if (160 > m_tx[i] - 56 && 128 < m_tx[i] && (m_y < m_th[i] || m_y + 32 > m_th[i] + 80)) col = 1;
      if (col) m_st = 1;
      else begin
        ny = m_y + m_vel;
        m_vel = flap ? -8 : (m_vel + 1 > 10 ? 10 : m_vel + 1);
        if (ny < 5) begin
          ny = 5;
          m_vel = 0;
        end
        m_y = ny;
        pass = 0;
        for (int i = 0; i < 5; i++) begin
          if (m_tx[i] > 128 && m_tx[i] <= 130) pass = 1;
          if (m_tx[i] <= 2) begin
            m_tx[i] = m_tx[i] + 798;
            m_th[i] = 64 + (m_lfsr & 255);
          end else m_tx[i] = m_tx[i] - 2;
        end
        if (pass && m_sc < 255) m_sc++;
      end
    end else begin
      if (flap && m_hold == 60) reset_model();
      else if (m_hold < 60) m_hold++;
    end
  endfunction
  always @(negedge clk)
    while (q.size() > 0 && int'(q[0].due) <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("state", int'(state), int'(e.st));
      chk("bird_loc_y", int'(bird_loc_y), int'(e.y));
      chk("score", int'(score), int'(e.sc));
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("tube%0d_x", i), int'(d_tx[i]), int'(e.tx[i]));
        chk($sformatf("tube%0d_h", i), int'(d_th[i]), int'(e.th[i]));
      end
    end
  task automatic frame(input bit flap);
    bit same;
    same = ($urandom_range(0, 3) == 0);
    if (flap && !same)
      repeat ($urandom_range(1, 2)) begin
        @(negedge clk); key_flap = 1'b1;
        @(negedge clk); key_flap = 1'b0;
      end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    vs_in = 1'b1;
    if (flap && same) key_flap = 1'b1;
    model_tick(flap);
    push();
    @(negedge clk); vs_in = 1'b0; key_flap = 1'b0;
    @(negedge clk);
  endtask
  task automatic do_reset(input bit vs_hi);
    @(negedge clk);
    #2 rst_n = 1'b0; vs_in = vs_hi; key_flap = 1'b0;
    reset_model();
    @(negedge clk); push();
    @(negedge clk); rst_n = 1'b1;
    if (vs_hi) key_flap = 1'b1;
    @(negedge clk); key_flap = 1'b0; push();
    repeat (2) @(negedge clk);
    vs_in = 1'b0;
    @(negedge clk);
  endtask
  function automatic bit pick(int mode);
    int best, h;
    if (m_st == 0) return bit'($urandom_range(0, 1));
    if (m_st == 1) return $urandom_range(0, 2) == 0;
    if (mode == 0) return 1'b0;
    if (mode == 2) return $urandom_range(0, 3) != 0;
    best = 4096; h = 160;
    for (int i = 0; i < 5; i++)
      if (m_tx[i] > 128 && m_tx[i] < best) begin
        best = m_tx[i];
        h = m_th[i];
      end
    return (m_y >= h + 26 && m_vel >= 0) || $urandom_range(0, 29) == 0;
  endfunction
  initial begin
    do_reset(1'b0);
    for (int g = 0; g < 6; g++) begin
      int n;
      bit ended;
      n = 0;
      ended = 0;
      while (!(ended && m_st == 0) && n < 900) begin
        if (m_st == 1) ended = 1;
        frame(pick(g % 3));
        n++;
      end
    end
    if (m_st == 0) frame(1'b1);
    repeat (4) frame(1'b0);
    @(negedge clk); key_flap = 1'b1;
    @(negedge clk); key_flap = 1'b0;
    do_reset(1'b0);
    frame(1'b0);
    do_reset(1'b1);
    frame(1'b1);
    repeat (3) frame(1'b0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
